// File: rtl/fb_text_writer.sv
// fb_text_writer: cursor-tracking glyph writer that read-modify-writes a 16-bit frame buffer
// holding two glyphs per word. Define FB_CLEAR_EN to build in the full-screen clear engine.

module fb_text_writer #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE     = 16'h3000,
  parameter int                    ROW_STRIDE  = 80,
  parameter int                    COLS        = 80,
  parameter int                    ROWS        = 60,
  parameter logic [7:0]            CLEAR_GLYPH = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  char_valid,
  input  logic [7:0]            char_data,
  output logic                  char_ready,
  input  logic                  clear_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [15:0]           mem_rdata,
  output logic [6:0]            cursor_x,
  output logic [5:0]            cursor_y,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3
`ifdef FB_CLEAR_EN
    ,
    CLR   = 3'd4
`endif
  } state_t;

  localparam logic [6:0] LAST_X = 7'(COLS - 1);
  localparam logic [5:0] LAST_Y = 6'(ROWS - 1);

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_CR = 8'h0D;

  state_t                r_state;
  state_t                w_state_next;
  logic [6:0]            r_cursor_x;
  logic [5:0]            r_cursor_y;
  logic [7:0]            r_code;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [15:0]           r_mem_wdata;
  logic                  r_mem_we;

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_printable;
  logic                  w_clear_start;
  logic [5:0]            w_nl_y;
  logic [6:0]            w_adv_x;
  logic [5:0]            w_adv_y;
  logic [6:0]            w_bs_x;
  logic [5:0]            w_bs_y;

  // Frame-buffer word address of a glyph row and word column, wrapping at ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [5:0] row,
                                                      input logic [5:0] wcol);
    logic [ADDR_WIDTH-1:0] w_row;
    logic [ADDR_WIDTH-1:0] w_col;
    w_row = ADDR_WIDTH'(row);
    w_col = ADDR_WIDTH'(wcol);
    return FB_BASE + ADDR_WIDTH'(ROW_STRIDE) * w_row + w_col;
  endfunction

  assign w_idle      = (r_state == IDLE);
  assign busy        = !w_idle;
  assign char_ready  = w_idle && !reset && !w_clear_start;
  assign w_accept    = char_valid && char_ready;
  assign w_printable = !(char_data inside {CODE_BS, CODE_LF, CODE_CR});

  // Cursor successors: line feed, printable advance and backspace all wrap without scrolling.
  assign w_nl_y  = (r_cursor_y == LAST_Y) ? 6'd0 : r_cursor_y + 6'd1;
  assign w_adv_x = (r_cursor_x == LAST_X) ? 7'd0 : r_cursor_x + 7'd1;
  assign w_adv_y = (r_cursor_x == LAST_X) ? w_nl_y : r_cursor_y;

  always_comb begin
    w_bs_x = r_cursor_x;
    w_bs_y = r_cursor_y;
    if (r_cursor_x != 7'd0) begin
      w_bs_x = r_cursor_x - 7'd1;
    end else if (r_cursor_y != 6'd0) begin
      w_bs_x = LAST_X;
      w_bs_y = r_cursor_y - 6'd1;
    end
  end

`ifdef FB_CLEAR_EN
  localparam logic [5:0] LAST_WCOL = 6'(COLS / 2 - 1);

  logic [5:0] r_clr_row;
  logic [5:0] r_clr_wcol;
  logic       w_clear_done;
  logic [5:0] w_clr_row_next;
  logic [5:0] w_clr_wcol_next;

  // Clear has priority over a character offered in the same cycle.
  assign w_clear_start   = w_idle && clear_req;
  assign w_clear_done    = (r_clr_row == LAST_Y) && (r_clr_wcol == LAST_WCOL);
  assign w_clr_wcol_next = (r_clr_wcol == LAST_WCOL) ? 6'd0 : r_clr_wcol + 6'd1;
  assign w_clr_row_next  = (r_clr_wcol == LAST_WCOL) ? r_clr_row + 6'd1 : r_clr_row;
`else
  logic w_unused_clear;

  assign w_clear_start  = 1'b0;
  assign w_unused_clear = clear_req ^ (^CLEAR_GLYPH);
`endif

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_printable) w_state_next = RD;
`ifdef FB_CLEAR_EN
        if (w_clear_start) w_state_next = CLR;
`endif
      end
      RD:    w_state_next = MERGE;
      MERGE: w_state_next = WR;
      WR:    w_state_next = IDLE;
`ifdef FB_CLEAR_EN
      CLR:   if (w_clear_done) w_state_next = IDLE;
`endif
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cursor_x  <= 7'd0;
      r_cursor_y  <= 6'd0;
      r_code      <= 8'h00;
      r_mem_addr  <= FB_BASE;
      r_mem_wdata <= 16'h0000;
      r_mem_we    <= 1'b0;
`ifdef FB_CLEAR_EN
      r_clr_row   <= 6'd0;
      r_clr_wcol  <= 6'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_printable) begin
              r_code     <= char_data;
              r_mem_addr <= word_addr(r_cursor_y, r_cursor_x[6:1]);
            end else if (char_data == CODE_LF) begin
              r_cursor_x <= 7'd0;
              r_cursor_y <= w_nl_y;
            end else if (char_data == CODE_CR) begin
              r_cursor_x <= 7'd0;
            end else begin
              r_cursor_x <= w_bs_x;
              r_cursor_y <= w_bs_y;
            end
          end
`ifdef FB_CLEAR_EN
          if (w_clear_start) begin
            r_clr_row   <= 6'd0;
            r_clr_wcol  <= 6'd0;
            r_mem_addr  <= FB_BASE;
            r_mem_wdata <= {CLEAR_GLYPH, CLEAR_GLYPH};
            r_mem_we    <= 1'b1;
          end
`endif
        end
        MERGE: begin
          // Even column owns the high byte; the neighbour glyph is carried over untouched.
          r_mem_wdata <= r_cursor_x[0] ? {mem_rdata[15:8], r_code}
                                       : {r_code, mem_rdata[7:0]};
          r_mem_we    <= 1'b1;
        end
        WR: begin
          r_mem_we   <= 1'b0;
          r_cursor_x <= w_adv_x;
          r_cursor_y <= w_adv_y;
        end
`ifdef FB_CLEAR_EN
        CLR: begin
          if (w_clear_done) begin
            r_mem_we   <= 1'b0;
            r_cursor_x <= 7'd0;
            r_cursor_y <= 6'd0;
          end else begin
            r_clr_row  <= w_clr_row_next;
            r_clr_wcol <= w_clr_wcol_next;
            r_mem_addr <= word_addr(w_clr_row_next, w_clr_wcol_next);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign cursor_x  = r_cursor_x;
  assign cursor_y  = r_cursor_y;

endmodule

// File: tb/tb_fb_text_writer.sv
// Bench for fb_text_writer: table of glyph/control codes with expected cursors, a RAM model,
// and a write scoreboard filled when stimulus is driven and drained by a negedge monitor.

module tb_fb_text_writer;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] code;
    logic [6:0] ex;
    logic [5:0] ey;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic        clear_req = 1'b0;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic        busy;

  always #5 clk = ~clk;

  fb_text_writer dut (
    .clk       (clk),
    .reset     (reset),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .clear_req (clear_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .busy      (busy)
  );

  // Synchronous-read RAM; unwritten words read as two spaces.
  logic [15:0] ram [0:65535];
  bit          ram_wr [0:65535];

  always @(posedge clk) begin
    mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : 16'h2020;
    if (mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
  end

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  int          n_writes = 0;
  logic [15:0] last_addr = 16'h0000;
  logic [15:0] last_wdata = 16'h0000;
  bit          in_clear = 1'b0;
  bit          prev_we = 1'b0;

  logic [15:0] m_ram [int];
  int          m_x = 0;
  int          m_y = 0;
  vec_t        vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: every write must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we) begin
        n_writes++;
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_wdata), 32'(e.data));
        end
        if (!in_clear) check("we_single_cycle", 32'(prev_we), 32'd0);
      end
      if (busy) check("ready_low_when_busy", 32'(char_ready), 32'd0);
      prev_we = mem_we;
    end
  end

  task automatic model_step(input logic [7:0] code);
    case (code)
      8'h0A: begin m_x = 0; m_y = (m_y == 59) ? 0 : m_y + 1; end
      8'h0D: m_x = 0;
      8'h08: begin
        if (m_x > 0) m_x = m_x - 1;
        else if (m_y > 0) begin m_x = 79; m_y = m_y - 1; end
      end
      default: begin
        if (m_x == 79) begin m_x = 0; m_y = (m_y == 59) ? 0 : m_y + 1; end
        else m_x = m_x + 1;
      end
    endcase
  endtask

  task automatic send(input logic [7:0] code);
    int          k;
    int          lat;
    bit          prn;
    int          a;
    logic [15:0] old;
    logic [15:0] nw;
    k = 0;
    while (!char_ready && k < 50) begin @(negedge clk); k++; end
    check("ready_before_send", 32'(char_ready), 32'd1);
    prn = !(code == 8'h08 || code == 8'h0A || code == 8'h0D);
    if (prn) begin
      a   = 'h3000 + 80 * m_y + m_x / 2;
      old = m_ram.exists(a) ? m_ram[a] : 16'h2020;
      nw  = (m_x % 2 == 1) ? {old[15:8], code} : {code, old[7:0]};
      m_ram[a] = nw;
      exp_q.push_back('{16'(a), nw});
    end
    char_valid = 1'b1;
    char_data  = code;
    @(negedge clk);
    char_valid = 1'b0;
    lat = 1;
    while (!char_ready && lat < 20) begin @(negedge clk); lat++; end
    check($sformatf("latency_%02h", code), 32'(lat), prn ? 32'd4 : 32'd1);
    model_step(code);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_x"}, 32'(cursor_x), 32'(m_x));
    check({tag, "_y"}, 32'(cursor_y), 32'(m_y));
  endtask

  initial begin
    int n;
    int wr0;

    vecs.push_back('{8'h08, 7'd0, 6'd0});
    vecs.push_back('{8'h41, 7'd1, 6'd0});
    vecs.push_back('{8'h42, 7'd2, 6'd0});
    vecs.push_back('{8'h43, 7'd3, 6'd0});
    vecs.push_back('{8'h44, 7'd4, 6'd0});
    vecs.push_back('{8'h45, 7'd5, 6'd0});
    vecs.push_back('{8'h0A, 7'd0, 6'd1});
    vecs.push_back('{8'h0A, 7'd0, 6'd2});
    vecs.push_back('{8'h08, 7'd79, 6'd1});
    vecs.push_back('{8'h0D, 7'd0, 6'd1});
    vecs.push_back('{8'h0A, 7'd0, 6'd2});
    vecs.push_back('{8'h0A, 7'd0, 6'd3});
    vecs.push_back('{8'h46, 7'd1, 6'd3});
    vecs.push_back('{8'h47, 7'd2, 6'd3});
    vecs.push_back('{8'h48, 7'd3, 6'd3});
    vecs.push_back('{8'h49, 7'd4, 6'd3});
    vecs.push_back('{8'h4A, 7'd5, 6'd3});
    vecs.push_back('{8'h0A, 7'd0, 6'd4});
    vecs.push_back('{8'h4B, 7'd1, 6'd4});
    vecs.push_back('{8'h4C, 7'd2, 6'd4});
    vecs.push_back('{8'h4D, 7'd3, 6'd4});
    vecs.push_back('{8'h4E, 7'd4, 6'd4});
    vecs.push_back('{8'h4F, 7'd5, 6'd4});
    vecs.push_back('{8'h50, 7'd6, 6'd4});
    vecs.push_back('{8'h51, 7'd7, 6'd4});
    vecs.push_back('{8'h0D, 7'd0, 6'd4});
    vecs.push_back('{8'h08, 7'd79, 6'd3});

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(char_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'h3000);
    check("rst_wdata", 32'(mem_wdata), 32'h0);
    check("rst_x", 32'(cursor_x), 32'd0);
    check("rst_y", 32'(cursor_y), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(char_ready), 32'd1);

    foreach (vecs[i]) begin
      send(vecs[i].code);
      check($sformatf("vec%0d_x", i), 32'(cursor_x), 32'(vecs[i].ex));
      check($sformatf("vec%0d_y", i), 32'(cursor_y), 32'(vecs[i].ey));
      if (vecs[i].code == 8'h41) begin
        check("first_addr", 32'(last_addr), 32'h3000);
        check("first_wdata", 32'(last_wdata), 32'h4120);
      end
      if (vecs[i].code == 8'h42) begin
        check("second_addr", 32'(last_addr), 32'h3000);
        check("second_wdata", 32'(last_wdata), 32'h4142);
      end
    end

    // Walk to (79,59) and write the very last glyph cell.
    for (int i = 0; i < 56; i++) send(8'h0A);
    check_cursor("bottom_row");
    for (int i = 0; i < 79; i++) send(8'h61);
    check_cursor("last_col");
    send(8'h5A);
    check("wrap_addr", 32'(last_addr), 32'h4297);
    check("wrap_wdata", 32'(last_wdata), 32'h615A);
    check("wrap_x", 32'(cursor_x), 32'd0);
    check("wrap_y", 32'(cursor_y), 32'd0);

    // Reset during the RD wait aborts the write and homes the cursor.
    send(8'h41);
    check_cursor("pre_abort");
    char_valid = 1'b1;
    char_data  = 8'h77;
    @(negedge clk);
    char_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_x", 32'(cursor_x), 32'd0);
    check("abort_y", 32'(cursor_y), 32'd0);
    check("abort_ready", 32'(char_ready), 32'd0);
    reset = 1'b0;
    m_x = 0;
    m_y = 0;
    repeat (5) @(negedge clk);

`ifdef FB_CLEAR_EN
    send(8'h43);
    in_clear = 1'b1;
    for (int r = 0; r < 60; r++)
      for (int w = 0; w < 40; w++)
        exp_q.push_back('{16'('h3000 + 80 * r + w), 16'h0000});
    wr0        = n_writes;
    clear_req  = 1'b1;
    char_valid = 1'b1;
    char_data  = 8'h55;
    @(negedge clk);
    clear_req  = 1'b0;
    char_valid = 1'b0;
    n = 0;
    while (busy && n < 3000) begin n++; @(negedge clk); end
    check("clear_busy_cycles", 32'(n), 32'd2400);
    check("clear_writes", 32'(n_writes - wr0), 32'd2400);
    check("clear_drained", 32'(exp_q.size()), 32'd0);
    check("clear_we_off", 32'(mem_we), 32'd0);
    check("clear_x", 32'(cursor_x), 32'd0);
    check("clear_y", 32'(cursor_y), 32'd0);
    in_clear = 1'b0;
    m_x = 0;
    m_y = 0;
    repeat (3) @(negedge clk);
    check("clear_char_dropped", 32'(n_writes - wr0), 32'd2400);

    in_clear = 1'b1;
    for (int r = 0; r < 60; r++)
      for (int w = 0; w < 40; w++)
        exp_q.push_back('{16'('h3000 + 80 * r + w), 16'h0000});
    wr0       = n_writes;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("clr_abort_we", 32'(mem_we), 32'd0);
    check("clr_abort_busy", 32'(busy), 32'd0);
    check("clr_abort_writes", 32'(n_writes - wr0), 32'd100);
    reset = 1'b0;
    exp_q.delete();
    in_clear = 1'b0;
    @(negedge clk);
    check("clr_abort_ready", 32'(char_ready), 32'd1);
`else
    // Without the clear engine clear_req has no effect on a character transfer.
    clear_req = 1'b1;
    send(8'h44);
    clear_req = 1'b0;
    check_cursor("clear_ignored");
    wr0 = n_writes;
    n   = 0;
    check("clear_ignored_last", 32'(last_wdata), 32'h4442);
    check("clear_ignored_idle", 32'(busy), 32'(n));
    check("clear_ignored_count", 32'(n_writes), 32'(wr0));
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_text_writer.md
# fb_text_writer

Write-side engine for the glyph frame buffer scanned by the VGA display path. Accepts a stream of 8-bit glyph codes from the CPU side, tracks a text cursor, and performs read-modify-write cycles into the 16-bit frame-buffer RAM. Each word packs two glyphs: even column in [15:8], odd column in [7:0]. Optionally bulk-clears the whole screen.

## Interface
- ADDR_WIDTH, 16, frame-buffer address width
- FB_BASE, 16'h3000, word address of glyph (0,0)
- ROW_STRIDE, 80, words between glyph rows
- COLS, 80, glyph columns (even)
- ROWS, 60, glyph rows
- CLEAR_GLYPH, 8'h00, glyph code written by clear

- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- char_valid  input  1  char_data valid
- char_data  input  8  glyph or control code
- char_ready  output  1  high only in IDLE and not in reset; transfer when valid && ready
- clear_req  input  1  start screen clear (FB_CLEAR_EN only)
- mem_addr  output  ADDR_WIDTH  registered RAM address
- mem_wdata  output  16  registered write data
- mem_we  output  1  registered write enable
- mem_rdata  input  16  RAM read data, valid the cycle after the RAM samples mem_addr
- cursor_x  output  7  current column, 0..COLS-1
- cursor_y  output  6  current row, 0..ROWS-1
- busy  output  1  high in any state other than IDLE

## Operation
- Word address = FB_BASE + ROW_STRIDE*cursor_y + cursor_x[6:1]. Arithmetic is performed at ADDR_WIDTH and truncated.
- States: IDLE, RD, MERGE, WR, CLR.
- IDLE, accepted printable code (any code except 0x08, 0x0A, 0x0D): latch the code, load mem_addr, go to RD.
- RD: one wait cycle while the RAM samples the address. Go to MERGE.
- MERGE: mem_wdata <= merge(mem_rdata, code). Replace [15:8] when cursor_x is even, [7:0] when odd; the other byte is preserved. mem_we <= 1. Go to WR.
- WR: mem_we <= 0. Advance the cursor. Go to IDLE.
- Cursor advance: x+1. At x=COLS-1 it goes to x=0, y+1. At y=ROWS-1 it goes to y=0 (wrap, no scroll).
- Control codes are handled entirely on the accept edge. There is no memory access and the state stays IDLE.
  - 0x0A: x=0, y+1, with the same wrap.
  - 0x0D: x=0.
  - 0x08: x-1. At x=0 with y>0 it goes to x=COLS-1, y-1. At (0,0) there is no change. Backspace does not erase.
- Both clear_req and char_valid high in IDLE: the clear wins and the character is not accepted.
- Reset: state=IDLE, mem_we=0, mem_wdata=0, mem_addr=FB_BASE, cursor=(0,0), busy=0, char_ready=0 during reset.
  - Reset mid-operation aborts the operation on that edge.
  - A write already presented (mem_we was high) is not undone.

## Timing
- Printable code accepted at edge E0: mem_addr valid after E0; mem_we=1 during the cycle after E2; cursor updates and char_ready returns after E3.
- Throughput: 1 printable per 4 cycles. Control codes: 1 per cycle, char_ready stays high.
- mem_we is high for exactly one cycle per printable code.
- mem_addr and mem_wdata are stable for the entire cycle in which mem_we is high.
- busy = !IDLE, derived combinationally from the state register.

## Configuration
- FB_CLEAR_EN defined:
  - clear_req in IDLE enters CLR. CLR writes {CLEAR_GLYPH, CLEAR_GLYPH} to every word, one per cycle, with mem_we held high.
  - Order: row 0..ROWS-1, word 0..COLS/2-1, for ROWS*COLS/2 cycles (2400 with defaults).
  - After the last write: mem_we=0, cursor=(0,0), go to IDLE.
  - char_ready is low for the whole clear.
- FB_CLEAR_EN undefined: clear_req is ignored, the CLR state and its counters do not exist, and all other behaviour is identical.

## Test plan
- After reset, send 0x41 with RAM word 0x3000 = 16'h2020 -> exactly one mem_we pulse: addr 0x3000, wdata 16'h4120; cursor (1,0).
- Then send 0x42 (RAM now holds 16'h4120) -> write addr 0x3000, wdata 16'h4142; cursor (2,0).
- Cursor at (79,59), send 0x5A -> write addr 0x4297, low byte 0x5A, high byte preserved; cursor wraps to (0,0).
- Cursor at (5,3), send 0x0A -> cursor (0,4) next cycle, no mem_we, char_ready stays high. Send 0x0D at (7,4) -> (0,4).
- Send 0x08 at (0,0) -> no change. Send 0x08 at (0,2) -> (79,1). Neither causes a memory write.
- FB_CLEAR_EN, clear_req and char_valid both high in IDLE:
  - 2400 consecutive writes of 16'h0000, addresses 0x3000 through 0x4297 with row gaps.
  - busy is high for the whole clear; the character is not accepted; cursor ends at (0,0).
  - Asserting reset at write 100 -> mem_we low on the next cycle, state IDLE.
